// File: rtl/sbox_sched_pkg.sv
// Shared constants and types for the masked S-box scheduler.
//   LATENCY_DEF / DATA_N_DEF / KEY_N_DEF : default pipeline depth and round sizes
//   LFSR_TAPS / RNG_RESET                : RNG feedback taps and reset/zero-seed value
//   SRC_DATA / SRC_KEY                   : result source encoding
package sbox_sched_pkg;

   localparam int unsigned LATENCY_DEF = 5;
   localparam int unsigned DATA_N_DEF  = 16;
   localparam int unsigned KEY_N_DEF   = 4;

   // x^32 + x^22 + x^2 + x + 1 -> taps at bits 31, 21, 1, 0 of a left-shifting register
   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
   localparam logic [31:0] RNG_RESET = 32'h0000_0001;

   localparam logic SRC_DATA = 1'b0;
   localparam logic SRC_KEY  = 1'b1;

   typedef struct packed {
      logic       valid;
      logic       src;
      logic [3:0] idx;
   } tag_t;

   // One Fibonacci step: shift left, feedback is parity of tapped bits
   function automatic logic [31:0] lfsrNext(input logic [31:0] s);
      return {s[30:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/sbox_rng.sv
// Free-running 32-bit LFSR supplying fresh masking randomness.
//   clk, rst     : clock, async active-high reset (state -> RNG_RESET)
//   seed_ld, seed: load seed instead of advancing; zero seed replaced by RNG_RESET
//   lfsr         : current register state
module sbox_rng
   import sbox_sched_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        seed_ld,
   input  logic [31:0] seed,
   output logic [31:0] lfsr
);

   // All-zero is the LFSR lock-up state, so it is never loaded
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         lfsr <= RNG_RESET;
      else if (seed_ld)
         lfsr <= (seed == 32'h0) ? RNG_RESET : seed;
      else
         lfsr <= lfsrNext(lfsr);
   end

endmodule

// File: rtl/sbox_sched.sv
// Issue scheduler for a shared masked GF(2^8) inversion pipeline.
//   d_* / k_*        : data and key requesters (valid/ready, two shares, byte index)
//   sb_in_sh*        : registered shares to the pipeline; sb_guards/sb_random: fresh RNG bits
//   sb_out_sh*       : pipeline output shares, passed through to res_sh*
//   res_valid/src/idx: tag of the result currently leaving the pipeline
//   data_done/key_done: pulse on the last result of a round; busy: anything in flight
module sbox_sched
   import sbox_sched_pkg::*;
#(
   parameter int unsigned LATENCY = LATENCY_DEF,
   parameter int unsigned DATA_N  = DATA_N_DEF,
   parameter int unsigned KEY_N   = KEY_N_DEF
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        seed_ld,
   input  logic [31:0] seed,
   input  logic        d_valid,
   output logic        d_ready,
   input  logic [7:0]  d_sh0,
   input  logic [7:0]  d_sh1,
   input  logic [3:0]  d_idx,
   input  logic        k_valid,
   output logic        k_ready,
   input  logic [7:0]  k_sh0,
   input  logic [7:0]  k_sh1,
   input  logic [1:0]  k_idx,
   output logic [7:0]  sb_in_sh0,
   output logic [7:0]  sb_in_sh1,
   output logic [7:0]  sb_guards,
   output logic [3:0]  sb_random,
   input  logic [7:0]  sb_out_sh0,
   input  logic [7:0]  sb_out_sh1,
   output logic        res_valid,
   output logic        res_src,
   output logic [3:0]  res_idx,
   output logic [7:0]  res_sh0,
   output logic [7:0]  res_sh1,
   output logic        data_done,
   output logic        key_done,
   output logic        busy
);

   localparam int unsigned DCW = (DATA_N > 1) ? $clog2(DATA_N) : 1;
   localparam int unsigned KCW = (KEY_N > 1) ? $clog2(KEY_N) : 1;

   logic [31:0]    lfsr;
   logic           lastGrant, lastGrantNext;
   logic           grantD, grantK;
   logic [7:0]     sh0Next, sh1Next;
   tag_t           tagQ    [LATENCY+1];
   tag_t           tagNext [LATENCY+1];
   tag_t           tagPre;
   logic [DCW-1:0] dataCnt, dataCntNext;
   logic [KCW-1:0] keyCnt, keyCntNext;
   logic           dataDoneNext, keyDoneNext, busyNext;

   // Randomness source
   sbox_rng uRng (
      .clk     (clk),
      .rst     (rst),
      .seed_ld (seed_ld),
      .seed    (seed),
      .lfsr    (lfsr)
   );

   assign sb_guards = lfsr[7:0];
   assign sb_random = lfsr[11:8];

   // Round-robin grant: a tie goes to whoever was not served last
   assign grantD  = !rst && d_valid && (!k_valid || (lastGrant == SRC_KEY));
   assign grantK  = !rst && k_valid && (!d_valid || (lastGrant == SRC_DATA));
   assign d_ready = grantD;
   assign k_ready = grantK;

   // Result side: tail of the tag pipe, shares straight from the inversion pipeline
   assign res_valid = tagQ[LATENCY].valid;
   assign res_src   = tagQ[LATENCY].src;
   assign res_idx   = tagQ[LATENCY].idx;
   assign res_sh0   = sb_out_sh0;
   assign res_sh1   = sb_out_sh1;

   // Next-state: issue capture, tag shift, round counters
   always_comb begin
      lastGrantNext = lastGrant;
      sh0Next       = 8'h00;
      sh1Next       = 8'h00;
      tagNext[0]    = '0;
      dataCntNext   = dataCnt;
      keyCntNext    = keyCnt;
      dataDoneNext  = 1'b0;
      keyDoneNext   = 1'b0;

      if (grantD) begin
         lastGrantNext = SRC_DATA;
         sh0Next       = d_sh0;
         sh1Next       = d_sh1;
         tagNext[0]    = '{valid: 1'b1, src: SRC_DATA, idx: d_idx};
      end else if (grantK) begin
         lastGrantNext = SRC_KEY;
         sh0Next       = k_sh0;
         sh1Next       = k_sh1;
         tagNext[0]    = '{valid: 1'b1, src: SRC_KEY, idx: {2'b00, k_idx}};
      end

      for (int unsigned i = 1; i <= LATENCY; i++)
         tagNext[i] = tagQ[i-1];

      busyNext = 1'b0;
      for (int unsigned i = 0; i <= LATENCY; i++)
         busyNext = busyNext | tagNext[i].valid;

      // Counters track the tag about to reach the tail so the pulse lines up with its result
      tagPre = tagQ[LATENCY-1];
      if (tagPre.valid && (tagPre.src == SRC_DATA)) begin
         if (dataCnt == DCW'(DATA_N - 1)) begin
            dataCntNext  = '0;
            dataDoneNext = 1'b1;
         end else begin
            dataCntNext = dataCnt + DCW'(1);
         end
      end
      if (tagPre.valid && (tagPre.src == SRC_KEY)) begin
         if (keyCnt == KCW'(KEY_N - 1)) begin
            keyCntNext  = '0;
            keyDoneNext = 1'b1;
         end else begin
            keyCntNext = keyCnt + KCW'(1);
         end
      end
   end

   // State registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lastGrant <= SRC_KEY;
         sb_in_sh0 <= 8'h00;
         sb_in_sh1 <= 8'h00;
         for (int unsigned i = 0; i <= LATENCY; i++)
            tagQ[i] <= '0;
         dataCnt   <= '0;
         keyCnt    <= '0;
         data_done <= 1'b0;
         key_done  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         lastGrant <= lastGrantNext;
         sb_in_sh0 <= sh0Next;
         sb_in_sh1 <= sh1Next;
         for (int unsigned i = 0; i <= LATENCY; i++)
            tagQ[i] <= tagNext[i];
         dataCnt   <= dataCntNext;
         keyCnt    <= keyCntNext;
         data_done <= dataDoneNext;
         key_done  <= keyDoneNext;
         busy      <= busyNext;
      end
   end

endmodule
